// File: rtl/bcd_seq_ctrl.sv
// Two-requester binary-to-BCD converter: round-robin accept, 14-step double-dabble,
// saturating 4-digit result with overflow flag and requester id.
module bcd_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [13:0] bin0,
  input  logic        req1,
  input  logic [13:0] bin1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        busy,
  output logic        done,
  output logic        done_id,
  output logic [3:0]  q,
  output logic [3:0]  b,
  output logic [3:0]  s,
  output logic [3:0]  g,
  output logic        ovf
);

  // state | meaning
  // IDLE  | waiting for a request; arbitrate and load operand on accept
  // SHIFT | 14 add-3/shift steps, then one edge to publish the result
  // DONE  | result published for one cycle, return to IDLE
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]  state;
  logic [29:0] sreg;
  logic [29:0] adj;
  logic [3:0]  cnt;
  logic        fin;
  logic        last;
  logic        cur_id;
  logic        cur_ovf;
  logic        pick;
  logic [13:0] pick_bin;

  // On a tie the requester not granted last wins; a lone request always wins.
  always_comb begin
    pick     = (req0 && req1) ? ~last : req1;
    pick_bin = pick ? bin1 : bin0;
  end

  always_comb begin
    adj = sreg;
    for (int k = 0; k < 4; k++) begin
      if (sreg[14 + 4*k +: 4] >= 4'd5)
        adj[14 + 4*k +: 4] = sreg[14 + 4*k +: 4] + 4'd3;
    end
  end

  assign busy = (state == SHIFT) || (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sreg    <= '0;
      cnt     <= '0;
      fin     <= 1'b0;
      last    <= 1'b1;
      cur_id  <= 1'b0;
      cur_ovf <= 1'b0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
      q       <= '0;
      b       <= '0;
      s       <= '0;
      g       <= '0;
      ovf     <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            sreg    <= {16'd0, pick_bin};
            cnt     <= '0;
            fin     <= 1'b0;
            last    <= pick;
            cur_id  <= pick;
            cur_ovf <= (pick_bin > 14'd9999);
            gnt0    <= ~pick;
            gnt1    <= pick;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (!fin) begin
            sreg <= {adj[28:0], 1'b0};
            if (cnt == 4'd13) fin <= 1'b1;
            else              cnt <= cnt + 4'd1;
          end else begin
            // Out-of-range operands leave garbage in the BCD field; saturate instead.
            state   <= DONE;
            done    <= 1'b1;
            done_id <= cur_id;
            ovf     <= cur_ovf;
            {q, b, s, g} <= cur_ovf ? 16'h9999 : sreg[29:14];
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
